// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern source: bars, gray ramp, checker, solid, stripes.
// Define VGA_PATTERN_BORDER_EN to overlay a 1-pixel all-ones border.
module vga_pattern_gen #(
    parameter int BITS_PER_COLOR = 4,
    parameter int HW             = 12,
    parameter int VW             = 12,
    parameter int LGBARS         = 3,
    parameter int CHK_LG         = 3,
    parameter int GSHIFT         = 2
) (
    input  logic                          i_pixclk,
    input  logic                          i_reset,
    input  logic [HW-1:0]                 i_width,
    input  logic [VW-1:0]                 i_height,
    input  logic                          i_rd,
    input  logic                          i_newline,
    input  logic                          i_newframe,
    input  logic [2:0]                    i_mode,
    input  logic [3*BITS_PER_COLOR-1:0]   i_color,
    output logic [3*BITS_PER_COLOR-1:0]   o_pixel,
    output logic [2:0]                    o_mode
);

    localparam int BPC   = BITS_PER_COLOR;
    localparam int PW    = 3 * BPC;
    localparam int NBARS = 2 ** LGBARS;

    localparam logic [BPC-1:0]    LVL75   = BPC'(3) << (BPC - 2);
    localparam logic [BPC-1:0]    LMAX    = '1;
    localparam logic [LGBARS-1:0] LASTBAR = LGBARS'(NBARS - 1);

    typedef enum logic [2:0] {
        M_BARS   = 3'd0,
        M_GRAY   = 3'd1,
        M_CHECK  = 3'd2,
        M_SOLID  = 3'd3,
        M_STRIPE = 3'd4
    } mode_t;

    logic [HW-1:0]     hpos, hedge, fcount;
    logic [VW-1:0]     ypos;
    logic [LGBARS-1:0] hbar;
    logic              dline;

    logic [HW-1:0]     step, hpos_nx, gl, ssum, sshift;
    logic [BPC-1:0]    glvl;
    logic [PW-1:0]     pix;

    // White, yellow, cyan, green, magenta, red, blue, black at 75% level
    function automatic logic [PW-1:0] bar_color(input logic [2:0] i);
        logic [BPC-1:0] r, g, b;
        r = i[1] ? '0 : LVL75;
        g = i[2] ? '0 : LVL75;
        b = i[0] ? '0 : LVL75;
        return {r, g, b};
    endfunction

    assign step    = i_width >> LGBARS;
    assign hpos_nx = hpos + HW'(1);
    assign gl      = hpos >> GSHIFT;
    assign glvl    = (gl > HW'(LMAX)) ? LMAX : gl[BPC-1:0];
    assign ssum    = hpos + HW'(ypos) + fcount;
    assign sshift  = ssum >> CHK_LG;

    always_comb begin
        pix = '0;
        unique case (mode_t'(o_mode))
            M_BARS:   pix = bar_color(3'(hbar));
            M_GRAY:   pix = {glvl, glvl, glvl};
            M_CHECK:  pix = (hpos[CHK_LG] ^ ypos[CHK_LG]) ? '1 : '0;
            M_SOLID:  pix = i_color;
            M_STRIPE: pix = bar_color(sshift[2:0]);
            default:  pix = '0;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (ypos == '0 || ypos == i_height - VW'(1) ||
            hpos == '0 || hpos == i_width - HW'(1))
            pix = '1;
`endif
    end

`ifndef VGA_PATTERN_BORDER_EN
    logic unused_height;
    assign unused_height = ^i_height;
`endif

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            o_pixel <= '0;
            o_mode  <= '0;
            hpos    <= '0;
            ypos    <= '0;
            hbar    <= '0;
            hedge   <= step;
            fcount  <= '0;
            dline   <= 1'b0;
        end else if (i_newframe) begin
            o_pixel <= '0;
            if (i_mode <= 3'd4)
                o_mode <= i_mode;
            fcount  <= fcount + HW'(1);
            ypos    <= '0;
            hpos    <= '0;
            hbar    <= '0;
            hedge   <= step;
            dline   <= 1'b0;
        end else if (i_newline) begin
            o_pixel <= '0;
            hpos    <= '0;
            hbar    <= '0;
            hedge   <= step;
            ypos    <= ypos + VW'(dline);
            dline   <= 1'b0;
        end else if (i_rd) begin
            o_pixel <= pix;
            hpos    <= hpos_nx;
            dline   <= 1'b1;
            // Advance to the next bar once the next pixel crosses the edge
            if (step != '0 && hpos_nx >= hedge && hbar != LASTBAR) begin
                hbar  <= hbar + LGBARS'(1);
                hedge <= hedge + step;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: vector table plus multi-cycle sequences.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] width = 12'd64;
    logic [11:0] height = 12'd480;
    logic        rd = 1'b0;
    logic        nl = 1'b0;
    logic        nf = 1'b0;
    logic [2:0]  mode_in = 3'd0;
    logic [11:0] color = 12'h000;
    logic [11:0] pixel;
    logic [2:0]  mode_out;

    int checks = 0;
    int failures = 0;

    vga_pattern_gen dut (
        .i_pixclk   (clk),
        .i_reset    (rst),
        .i_width    (width),
        .i_height   (height),
        .i_rd       (rd),
        .i_newline  (nl),
        .i_newframe (nf),
        .i_mode     (mode_in),
        .i_color    (color),
        .o_pixel    (pixel),
        .o_mode     (mode_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic [11:0] w;
        int          line;
        int          hpos;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [11:0] bar_tab [8] = '{12'hCCC, 12'hCC0, 12'h0CC, 12'h0C0,
                                 12'hC0C, 12'hC00, 12'h00C, 12'h000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic frame(input logic [2:0] m);
        mode_in = m;
        nf = 1'b1;
        tick();
        nf = 1'b0;
    endtask

    task automatic line();
        nl = 1'b1;
        tick();
        nl = 1'b0;
    endtask

    task automatic pix(input int n);
        rd = 1'b1;
        repeat (n) tick();
        rd = 1'b0;
    endtask

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] bexp(input int h, input int y,
                                         input logic [11:0] e);
`ifdef VGA_PATTERN_BORDER_EN
        if (y == 0 || y == int'(height) - 1 || h == 0 || h == int'(width) - 1)
            return 12'hFFF;
`endif
        return e;
    endfunction

    task automatic add(input string n, input logic [2:0] m,
                       input logic [11:0] w, input int l, input int h,
                       input logic [11:0] e);
        vec_t v;
        v.name = n; v.mode = m; v.w = w; v.line = l; v.hpos = h; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        add("bar_h0",    3'd0, 12'd64,  0, 0,   12'hCCC);
        add("bar_h8",    3'd0, 12'd64,  0, 8,   12'hCC0);
        add("bar_h23",   3'd0, 12'd64,  0, 23,  12'h0CC);
        add("bar_h32",   3'd0, 12'd64,  0, 32,  12'hC0C);
        add("bar_h40",   3'd0, 12'd64,  0, 40,  12'hC00);
        add("bar_h63",   3'd0, 12'd64,  0, 63,  12'h000);
        add("gray_h0",   3'd1, 12'd128, 0, 0,   12'h000);
        add("gray_h4",   3'd1, 12'd128, 0, 4,   12'h111);
        add("gray_h20",  3'd1, 12'd128, 0, 20,  12'h555);
        add("gray_h60",  3'd1, 12'd128, 0, 60,  12'hFFF);
        add("gray_h127", 3'd1, 12'd128, 0, 127, 12'hFFF);
        add("chk_y0h7",  3'd2, 12'd64,  0, 7,   12'h000);
        add("chk_y0h8",  3'd2, 12'd64,  0, 8,   12'hFFF);
        add("chk_y0h15", 3'd2, 12'd64,  0, 15,  12'hFFF);
        add("chk_y8h0",  3'd2, 12'd64,  8, 0,   12'hFFF);
        add("chk_y8h8",  3'd2, 12'd64,  8, 8,   12'h000);
        add("solid_h3",  3'd3, 12'd64,  0, 3,   12'h5A3);
        add("strp_y0h0", 3'd4, 12'd64,  0, 0,   12'hCCC);
        add("strp_y0h7", 3'd4, 12'd64,  0, 7,   12'hCC0);
        add("strp_y3h5", 3'd4, 12'd64,  3, 5,   12'hCC0);
        add("strp_y8h8", 3'd4, 12'd64,  8, 8,   12'h0CC);

        do_reset();
        check("rst_pixel", pixel, 12'h000);
        check("rst_mode", {9'd0, mode_out}, 12'h000);

        color = 12'h5A3;
        foreach (vecs[i]) begin
            do_reset();
            width = vecs[i].w;
            height = 12'd480;
            frame(vecs[i].mode);
            repeat (vecs[i].line) begin
                line();
                pix(1);
            end
            line();
            pix(vecs[i].hpos + 1);
            check(vecs[i].name, pixel,
                  bexp(vecs[i].hpos, vecs[i].line, vecs[i].exp));
        end

        // Bars, one pixel per cycle with latency 1
        do_reset();
        width = 12'd64;
        frame(3'd0);
        line();
        check("nl_clear", pixel, 12'h000);
        for (int i = 0; i < 64; i++) begin
            rd = 1'b1;
            tick();
            check($sformatf("bar_stream%0d", i), pixel,
                  bexp(i, 0, bar_tab[i / 8]));
        end
        rd = 1'b0;
        tick();
        check("idle_hold", pixel, bexp(63, 0, 12'h000));

        // Empty line must not advance ypos
        do_reset();
        frame(3'd2);
        repeat (7) begin
            line();
            pix(1);
        end
        line();
        line();
        pix(1);
        check("empty_line", pixel, bexp(0, 7, 12'h000));

        // Mode only switches at frame start
        do_reset();
        color = 12'h000;
        frame(3'd0);
        line();
        pix(4);
        mode_in = 3'd3;
        color = 12'h123;
        pix(1);
        check("latch_pix", pixel, bexp(4, 0, 12'hCCC));
        check("latch_mode0", {9'd0, mode_out}, 12'd0);
        frame(3'd3);
        check("latch_mode3", {9'd0, mode_out}, 12'd3);
        check("nf_clear", pixel, 12'h000);
        line();
        pix(1);
        check("solid_123", pixel, bexp(0, 0, 12'h123));
        frame(3'd6);
        check("mode6_keep", {9'd0, mode_out}, 12'd3);

        // Stripes scroll with frame count
        do_reset();
        frame(3'd4);
        line();
        pix(1);
        check("scroll_f1", pixel, bexp(0, 0, 12'hCCC));
        repeat (8) frame(3'd4);
        line();
        pix(1);
        check("scroll_f9", pixel, bexp(0, 0, 12'hCC0));

        // Reset in the middle of a line
        line();
        pix(5);
        rd = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_pix", pixel, 12'h000);
        check("mid_rst_mode", {9'd0, mode_out}, 12'd0);
        check("mid_rst_fcnt", dut.fcount, 12'd0);
        tick();
        rd = 1'b0;
        check("post_rst_pix", pixel, bexp(0, 0, 12'hCCC));

`ifdef VGA_PATTERN_BORDER_EN
        do_reset();
        width = 12'd64;
        height = 12'd8;
        frame(3'd2);
        for (int y = 0; y < 8; y++) begin
            line();
            for (int h = 0; h < 64; h++) begin
                rd = 1'b1;
                tick();
                check($sformatf("border_y%0d_h%0d", y, h), pixel,
                      bexp(h, y, (((h >> 3) ^ (y >> 3)) & 1) != 0
                                 ? 12'hFFF : 12'h000));
            end
            rd = 1'b0;
        end
`else
        do_reset();
        width = 12'd64;
        height = 12'd8;
        frame(3'd2);
        line();
        pix(1);
        check("no_border", pixel, 12'h000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Multi-mode, parametrised VGA test-pattern source, the successor to the fixed colour-bar generator. It sits between the VGA timing core and the pixel output mux. For every `i_rd` it supplies one registered pixel, and it has five selectable patterns: colour bars, gray ramp, checkerboard, solid colour and scrolling diagonal stripes. Bar count, colour depth and geometry widths are generic. The mode is switched only on frame boundaries.

Parameters:
- BITS_PER_COLOR, 4, bits per colour channel (BPC); must be ≥2; pixel is 3*BPC bits, ordered {R,G,B}.
- HW, 12, width of the horizontal size and position counters.
- VW, 12, width of the vertical size and position counters.
- LGBARS, 3, log2 of the number of vertical bars (NBARS = 2**LGBARS); range 1..4.
- CHK_LG, 3, log2 of the checker cell and stripe width in pixels.
- GSHIFT, 2, right shift applied to hpos to form the gray-ramp level.

Ports:
- i_pixclk  in  1  pixel clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_width  in  HW  active pixels per line.
- i_height  in  VW  active lines per frame.
- i_rd  in  1  pixel request; one pixel is consumed per asserted cycle.
- i_newline  in  1  start-of-line strobe.
- i_newframe  in  1  start-of-frame strobe.
- i_mode  in  3  requested pattern; sampled only at a frame start.
- i_color  in  3*BPC  colour used by the solid-colour mode.
- o_pixel  out  3*BPC  registered pixel.
- o_mode  out  3  pattern currently active.

Behaviour:
- **Clock and reset:** one clock, i_pixclk. i_reset is synchronous and active-high.
- **Reset values:** o_pixel=0, o_mode=0, hpos=0, ypos=0, hbar=0, fcount=0, dline=0.
- **Priority:** i_reset > i_newframe > i_newline > i_rd.
- **Line-has-pixels flag (dline):** cleared by i_newline or i_newframe; set by i_rd.
- **Horizontal counters:**
  - i_newline clears hpos and hbar and loads hedge = step, where step = i_width >> LGBARS.
  - On each i_rd, hpos increments, wrapping modulo 2**HW.
  - When step ≠ 0, hpos+1 ≥ hedge and hbar ≠ NBARS-1: hbar increments and hedge += step.
  - Result: bar(x) = min(x/step, NBARS-1). If step = 0, hbar stays 0.
- **Vertical counter:** on i_newline, ypos += dline. Lines with no i_rd do not advance ypos. i_newframe clears ypos.
- **Frame start (i_newframe):**
  - o_mode <= i_mode if i_mode ≤ 4; any other value keeps the previous mode.
  - fcount increments, wrapping at 2**HW.
- **Output timing:**
  - o_pixel updates one cycle after i_rd, computed from pre-increment hpos, ypos and hbar (latency 1).
  - On i_newline or i_newframe, o_pixel <= 0.
  - With no strobe and no i_rd, o_pixel holds.
- **Colour table:** index i (0..7) gives R=~i[1], G=~i[2], B=~i[0]. Each asserted channel carries the 75% level {2'b11,0…}; each deasserted channel carries 0. Sequence is white, yellow, cyan, green, magenta, red, blue, black.
- **Modes:**
  - **0 – bars:** table[hbar[2:0]]. When NBARS=16, bars 8..15 repeat the table.
  - **1 – gray ramp:** L = hpos >> GSHIFT, saturated to 2**BPC-1; pixel = {L,L,L}.
  - **2 – checkerboard:** if (hpos>>CHK_LG ^ ypos>>CHK_LG) bit0 is 1, pixel is all-ones; otherwise 0.
  - **3 – solid:** i_color, sampled at the i_rd cycle.
  - **4 – scrolling stripes:** s = (hpos+ypos+fcount) >> CHK_LG, computed modulo 2**HW; pixel = table[s[2:0]]. The pattern shifts one pixel per frame.
- **Mode change mid-frame:** i_mode changes are ignored until the next i_newframe. No partial-frame switching.
- **Reset mid-line:** the next pixels use mode 0, hpos=0 and ypos=0.

Optional Feature:
- **Macro:** VGA_PATTERN_BORDER_EN.
- **When defined:** a 1-pixel all-ones border overrides the pattern when:
  - ypos == 0, or
  - ypos == i_height-1, or
  - hpos == 0, or
  - hpos == i_width-1.
- **When not defined:** no border logic is present, and the pattern covers the full raster.

Test Plan:
1. **Bars:** BPC=4, LGBARS=3, width=64, mode 0; reset, newframe, newline, then 64 i_rd. Required:
   - pixels 0–7 = 0xCCC, 8–15 = 0xCC0, 16–23 = 0x0CC;
   - pixels 56–63 = 0x000;
   - each pixel appears exactly one cycle after its i_rd.
2. **Gray ramp:** mode 1, GSHIFT=2, width=128. Required: hpos 0 → 0x000, hpos 20 → 0x555, hpos 60 → 0xFFF (saturated), hpos 127 → 0xFFF.
3. **Checkerboard:** mode 2, CHK_LG=3. Required:
   - line 0: hpos 0–7 → 0x000, hpos 8–15 → 0xFFF;
   - the line with ypos=8: hpos 0 → 0xFFF.
   - A line with no i_rd does not advance ypos.
4. **Mode latch:** in mode 0, set i_mode=3 and i_color=0x123 mid-frame. Required: pixels stay bars and o_mode=0 until i_newframe; after it, o_mode=3 and pixels = 0x123. i_mode=6 at the following frame start keeps o_mode=3.
5. **Scroll and reset:** mode 4, CHK_LG=3. Required:
   - pixel at hpos 0, ypos 0 is table[0] = 0xCCC at frame 1;
   - after 8 newframes, it is table[1] = 0xCC0.
   - Assert i_reset mid-line: o_pixel=0, o_mode=0 and fcount=0 on the next cycle.
6. **Border (VGA_PATTERN_BORDER_EN):** width=64, height=8, mode 2. Required: row 0 all 0xFFF; hpos 0 and hpos 63 = 0xFFF on every row; row 7 all 0xFFF. Without the macro, row 0 hpos 0 = 0x000.
